// File: rtl/sc_reg_ir_queue_if.sv
// Handshake/bus bundle for the instruction-register queue: push/pop/flush controls in, head word and decoded fields out.
// The optional sign-extended immediate output exists only when SC_RegIRQ_SIMM13_EN is defined.
interface sc_reg_ir_queue_if #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DEPTH                   = 4,
    parameter int DATAWIDTH_BUS_REG_IR    = 5,
    parameter int DATAWIDTH_BUS_REG_IR_OP = 8
);
    localparam int COUNTWIDTH = $clog2(DEPTH) + 1;

    logic                               SC_RegIRQ_Write_InLow;
    logic                               SC_RegIRQ_Pop_InLow;
    logic                               SC_RegIRQ_Flush_InHigh;
    logic [DATAWIDTH_BUS-1:0]           SC_RegIRQ_DataBUS_In;

    logic [DATAWIDTH_BUS-1:0]           SC_RegIRQ_DataBUS_Out;
    logic [DATAWIDTH_BUS_REG_IR-1:0]    SC_RegIRQ_DataBUS_RS1;
    logic [DATAWIDTH_BUS_REG_IR-1:0]    SC_RegIRQ_DataBUS_RS2;
    logic [DATAWIDTH_BUS_REG_IR-1:0]    SC_RegIRQ_DataBUS_RD;
    logic [DATAWIDTH_BUS_REG_IR_OP-1:0] SC_RegIRQ_DataBUS_OP;
    logic                               SC_RegIRQ_DataBUS_IR13;
    logic                               SC_RegIRQ_Empty_Out;
    logic                               SC_RegIRQ_Full_Out;
    logic [COUNTWIDTH-1:0]              SC_RegIRQ_Count_Out;
    logic                               SC_RegIRQ_Overflow_Out;
`ifdef SC_RegIRQ_SIMM13_EN
    logic [DATAWIDTH_BUS-1:0]           SC_RegIRQ_DataBUS_SIMM_Out;
`endif

    modport master (
        output SC_RegIRQ_Write_InLow,
        output SC_RegIRQ_Pop_InLow,
        output SC_RegIRQ_Flush_InHigh,
        output SC_RegIRQ_DataBUS_In,
        input  SC_RegIRQ_DataBUS_Out,
        input  SC_RegIRQ_DataBUS_RS1,
        input  SC_RegIRQ_DataBUS_RS2,
        input  SC_RegIRQ_DataBUS_RD,
        input  SC_RegIRQ_DataBUS_OP,
        input  SC_RegIRQ_DataBUS_IR13,
        input  SC_RegIRQ_Empty_Out,
        input  SC_RegIRQ_Full_Out,
        input  SC_RegIRQ_Count_Out,
`ifdef SC_RegIRQ_SIMM13_EN
        input  SC_RegIRQ_DataBUS_SIMM_Out,
`endif
        input  SC_RegIRQ_Overflow_Out
    );

    modport slave (
        input  SC_RegIRQ_Write_InLow,
        input  SC_RegIRQ_Pop_InLow,
        input  SC_RegIRQ_Flush_InHigh,
        input  SC_RegIRQ_DataBUS_In,
        output SC_RegIRQ_DataBUS_Out,
        output SC_RegIRQ_DataBUS_RS1,
        output SC_RegIRQ_DataBUS_RS2,
        output SC_RegIRQ_DataBUS_RD,
        output SC_RegIRQ_DataBUS_OP,
        output SC_RegIRQ_DataBUS_IR13,
        output SC_RegIRQ_Empty_Out,
        output SC_RegIRQ_Full_Out,
        output SC_RegIRQ_Count_Out,
`ifdef SC_RegIRQ_SIMM13_EN
        output SC_RegIRQ_DataBUS_SIMM_Out,
`endif
        output SC_RegIRQ_Overflow_Out
    );
endinterface

// File: rtl/sc_reg_ir_queue.sv
// Instruction-word FIFO with combinational head decode (RS1/RS2/RD/OP/IR13, optional SIMM13 under SC_RegIRQ_SIMM13_EN).
// Latency: a word pushed into an empty queue shows on the head outputs one cycle after the push edge.
// Backpressure: push while full (no pop) is dropped and raises sticky Overflow; pop while empty is ignored.
module sc_reg_ir_queue #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DEPTH                   = 4,
    parameter int DATAWIDTH_BUS_REG_IR    = 5,
    parameter int DATAWIDTH_BUS_REG_IR_OP = 8
) (
    input  logic              SC_RegIRQ_CLOCK_50,
    input  logic              SC_RegIRQ_RESET_InHigh,
    sc_reg_ir_queue_if.slave  irqBus
);
    localparam int PTRWIDTH   = $clog2(DEPTH);
    localparam int COUNTWIDTH = PTRWIDTH + 1;

    typedef logic [PTRWIDTH-1:0]      ptr_t;
    typedef logic [COUNTWIDTH-1:0]    count_t;
    typedef logic [DATAWIDTH_BUS-1:0] word_t;

    generate
        if (DATAWIDTH_BUS < 32) begin : gWidthCheck
            $error("sc_reg_ir_queue: DATAWIDTH_BUS must be at least 32");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gDepthCheck
            $error("sc_reg_ir_queue: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    word_t  storeMem [DEPTH];
    ptr_t   wrPtr;
    ptr_t   rdPtr;
    count_t entryCount;
    logic   overflowFlag;

    logic   pushReq;
    logic   popReq;
    logic   flushReq;
    logic   queueEmpty;
    logic   queueFull;
    logic   popAcc;
    logic   pushAcc;
    logic   pushDrop;
    logic   memWrEn;
    word_t  headWord;

    assign pushReq  = ~irqBus.SC_RegIRQ_Write_InLow;
    assign popReq   = ~irqBus.SC_RegIRQ_Pop_InLow;
    assign flushReq = irqBus.SC_RegIRQ_Flush_InHigh;

    assign queueEmpty = (entryCount == '0);
    assign queueFull  = (entryCount == count_t'(DEPTH));

    // A full queue still accepts a push when the same edge frees the head slot.
    assign popAcc   = popReq & ~queueEmpty;
    assign pushAcc  = pushReq & (~queueFull | popAcc);
    assign pushDrop = pushReq & queueFull & ~popAcc;

    // Reset and flush both override any same-cycle push into storage.
    assign memWrEn = pushAcc & ~flushReq & ~SC_RegIRQ_RESET_InHigh;

    always_ff @(posedge SC_RegIRQ_CLOCK_50) begin
        if (SC_RegIRQ_RESET_InHigh) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            entryCount   <= '0;
            overflowFlag <= 1'b0;
        end else if (flushReq) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            entryCount   <= '0;
            overflowFlag <= 1'b0;
        end else begin
            if (pushAcc) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popAcc) begin
                rdPtr <= rdPtr + 1'b1;
            end
            entryCount <= entryCount + count_t'(pushAcc) - count_t'(popAcc);
            if (pushDrop) begin
                overflowFlag <= 1'b1;
            end
        end
    end

    // Storage is never cleared; validity is tracked by the pointers and count alone.
    always_ff @(posedge SC_RegIRQ_CLOCK_50) begin
        if (memWrEn) begin
            storeMem[wrPtr] <= irqBus.SC_RegIRQ_DataBUS_In;
        end
    end

    assign headWord = queueEmpty ? '0 : storeMem[rdPtr];

    // Field positions are fixed to the 32-bit instruction format for any bus width.
    assign irqBus.SC_RegIRQ_DataBUS_Out  = headWord;
    assign irqBus.SC_RegIRQ_DataBUS_RS1  = DATAWIDTH_BUS_REG_IR'(headWord[18:14]);
    assign irqBus.SC_RegIRQ_DataBUS_RS2  = DATAWIDTH_BUS_REG_IR'(headWord[4:0]);
    assign irqBus.SC_RegIRQ_DataBUS_RD   = DATAWIDTH_BUS_REG_IR'(headWord[29:25]);
    assign irqBus.SC_RegIRQ_DataBUS_OP   = DATAWIDTH_BUS_REG_IR_OP'({headWord[31:30], headWord[24:19]});
    assign irqBus.SC_RegIRQ_DataBUS_IR13 = headWord[13];

    assign irqBus.SC_RegIRQ_Empty_Out    = queueEmpty;
    assign irqBus.SC_RegIRQ_Full_Out     = queueFull;
    assign irqBus.SC_RegIRQ_Count_Out    = entryCount;
    assign irqBus.SC_RegIRQ_Overflow_Out = overflowFlag;

`ifdef SC_RegIRQ_SIMM13_EN
    assign irqBus.SC_RegIRQ_DataBUS_SIMM_Out = {{(DATAWIDTH_BUS-13){headWord[12]}}, headWord[12:0]};
`endif

endmodule
